pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Parametrised reset sequencer between one or more PLLs and the SoC clock domains. It holds the PLLs in reset for a fixed time and waits until all lock indicators have been stable for a set time. It then releases per-domain resets in a fixed staggered order. On lock loss it re-arms the whole sequence automatically, with timeout retry and saturating event counters. It is the next generation of the single "reset = !pll_locked" hookup in the chip tops, and sits between the PLL primitives and the core's reset inputs.

## Interface
Parameters:
- NUM_LOCKS, 1: number of PLL lock inputs; all must be high to count as locked.
- NUM_DOMAINS, 2: number of staged domain reset outputs (≥1).
- PLL_RST_CYCLES, 16: cycles pll_rst is held per attempt (≥1).
- LOCK_STABLE_CYCLES, 256: consecutive locked cycles required before release (≥1).
- STAGE_DELAY_CYCLES, 32: cycles between successive domain releases (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles in WAIT_LOCK before retry; 0 disables the timeout.

Ports:
- sys_clock  in  1  sole clock; the block is referenced to the pre-PLL oscillator.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  NUM_LOCKS  raw, asynchronous PLL lock flags.
- sw_reset_req  in  1  sync single-cycle request to re-sequence the domains without resetting the PLLs.
- pll_rst  out  1  active-high PLL reset.
- domain_reset  out  NUM_DOMAINS  active-high domain resets; bit 0 is released first.
- all_ready  out  1  high when every domain is out of reset.
- relock_count  out  8  saturating count of lock losses seen in RELEASE/RUN.
- timeout_count  out  8  saturating count of WAIT_LOCK timeouts.

## Operation
- Synchroniser: each pll_locked bit passes through a 2-flop synchroniser clocked always, including in PLL_RST. lock_ok is the AND of the synchronised bits.
- Reset (reset_n=0), all outputs asynchronously forced:
  - pll_rst=1, domain_reset=all 1, all_ready=0.
  - Both counters 0, state=PLL_RST, internal counters 0, synchronisers 0.
- PLL_RST:
  - pll_rst=1, all domain resets held.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK; clear the stable and timeout counters.
- WAIT_LOCK:
  - pll_rst=0.
  - Stable counter increments while lock_ok=1 and clears to 0 on any cycle with lock_ok=0.
  - When it reaches LOCK_STABLE_CYCLES, go to RELEASE with stage index 0.
  - Timeout counter increments every cycle. When it reaches LOCK_TIMEOUT_CYCLES (if nonzero) with the stable condition unmet, go to PLL_RST and increment timeout_count (saturating at 255).
  - If stable and timeout complete in the same cycle, stable wins.
- RELEASE:
  - On entry, clear domain_reset[0].
  - Every STAGE_DELAY_CYCLES thereafter, clear the next bit.
  - The cycle the last bit clears, set all_ready=1 and go to RUN.
  - With NUM_DOMAINS=1, RUN is entered together with the first release.
- RUN: hold all outputs.
- Lock loss (lock_ok=0 in RELEASE or RUN):
  - Next edge: domain_reset=all 1, all_ready=0, pll_rst=1, state=PLL_RST.
  - relock_count increments, saturating at 255.
- sw_reset_req in RELEASE or RUN:
  - Next edge: domain_reset=all 1, all_ready=0, state=WAIT_LOCK with counters cleared. The PLL is not reset and no counter increments.
  - sw_reset_req is ignored in PLL_RST and WAIT_LOCK.
  - If lock loss and sw_reset_req occur in the same cycle, lock loss wins.
- Ordering invariant: domain_reset bits never deassert out of order. No bit is ever low while a lower-indexed bit is high.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Synchroniser latency is 2 cycles from a pll_locked change to lock_ok.
- Lock loss reaches domain_reset in at most 3 edges: 2 synchroniser edges plus 1 state edge.
- Release latency with locks already stable: PLL_RST_CYCLES + LOCK_STABLE_CYCLES edges from reset_n deassertion to domain_reset[0]=0.
  - This assumes the synchroniser has already filled during PLL_RST, which holds when PLL_RST_CYCLES ≥ 2.
- Each subsequent domain release follows exactly STAGE_DELAY_CYCLES edges later.
- reset_n asserted mid-sequence forces the reset values immediately (asynchronously). The sequence restarts from PLL_RST on the first edge after deassertion.
- Counter widths: each internal counter is sized to $clog2(parameter+1) and never wraps.

## Test plan
Bench parameters unless stated: NUM_LOCKS=2, NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, STAGE_DELAY_CYCLES=5, LOCK_TIMEOUT_CYCLES=64.
- Clean bring-up: both locks high throughout, reset_n released at edge 0.
  - pll_rst falls after edge 4.
  - domain_reset becomes 3'b110 at edge 12, 3'b100 at edge 17, 3'b000 at edge 22, with all_ready=1 at edge 22.
  - Both counters stay 0.
- Lock glitch during WAIT_LOCK: lock[1] drops for 1 cycle after 6 stable cycles.
  - The stable counter restarts; the first release occurs 8 cycles after lock_ok returns.
  - No counter increments.
- Timeout: lock[0] held low.
  - pll_rst pulses for 4 cycles every 68 cycles.
  - timeout_count reads 1, 2, 3 after successive attempts.
  - Domains stay in reset and all_ready stays 0.
- Lock loss in RUN: drop lock[0] for 1 cycle.
  - Within 3 edges: domain_reset=3'b111, all_ready=0, pll_rst=1, relock_count=1.
  - Full re-sequence as in the clean bring-up once the lock returns.
- sw_reset_req in RUN, and simultaneously with lock loss:
  - Alone: domain_reset=3'b111 next edge, pll_rst stays 0, release restarts 8 cycles later, counters unchanged.
  - Simultaneous with lock loss: PLL_RST path taken and relock_count increments.
- Saturation and async reset:
  - Force 300 timeouts: timeout_count holds at 255.
  - Assert reset_n low mid-RELEASE: outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL lock flags, the reset sequencer and the domain resets.
interface pll_reset_sequencer_if #(
  parameter int unsigned NUM_LOCKS   = 1,
  parameter int unsigned NUM_DOMAINS = 2
);
  logic [NUM_LOCKS-1:0]   pll_locked;
  logic                   sw_reset_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic                   all_ready;
  logic [7:0]             relock_count;
  logic [7:0]             timeout_count;

  modport master (
    output pll_locked, sw_reset_req,
    input  pll_rst, domain_reset, all_ready, relock_count, timeout_count
  );

  modport slave (
    input  pll_locked, sw_reset_req,
    output pll_rst, domain_reset, all_ready, relock_count, timeout_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Holds PLLs in reset, waits for stable lock, then releases domain resets in staggered order.
// Re-arms on lock loss or software request; counts relocks and lock timeouts.
module pll_reset_sequencer #(
  parameter int unsigned NUM_LOCKS           = 1,
  parameter int unsigned NUM_DOMAINS         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned STAGE_DELAY_CYCLES  = 32,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input logic                  sys_clock,
  input logic                  reset_n,
  pll_reset_sequencer_if.slave bus
);

  localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned STG_W = $clog2(STAGE_DELAY_CYCLES + 1);
  localparam int unsigned TO_W  = (LOCK_TIMEOUT_CYCLES > 0) ? $clog2(LOCK_TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN = (LOCK_TIMEOUT_CYCLES != 0);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGE_DELAY_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_EN ? LOCK_TIMEOUT_CYCLES - 1 : 0);

  localparam logic [NUM_DOMAINS-1:0] ALL_ON    = '1;
  localparam logic [NUM_DOMAINS-1:0] FIRST_REL = ALL_ON << 1;

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                 r_state, w_state;
  logic [NUM_LOCKS-1:0]   r_sync1, r_sync2;
  logic [RST_W-1:0]       r_rst_cnt, w_rst_cnt;
  logic [STB_W-1:0]       r_stable_cnt, w_stable_cnt;
  logic [TO_W-1:0]        r_timeout_cnt, w_timeout_cnt;
  logic [STG_W-1:0]       r_stage_cnt, w_stage_cnt;
  logic                   r_pll_rst, w_pll_rst;
  logic [NUM_DOMAINS-1:0] r_domain_reset, w_domain_reset;
  logic                   r_all_ready, w_all_ready;
  logic [7:0]             r_relock_count, w_relock_count;
  logic [7:0]             r_timeout_count, w_timeout_count;
  logic                   w_lock_ok;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lock_ok = &r_sync2;

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_PLL_RST;
      r_rst_cnt       <= '0;
      r_stable_cnt    <= '0;
      r_timeout_cnt   <= '0;
      r_stage_cnt     <= '0;
      r_pll_rst       <= 1'b1;
      r_domain_reset  <= '1;
      r_all_ready     <= 1'b0;
      r_relock_count  <= '0;
      r_timeout_count <= '0;
    end else begin
      r_state         <= w_state;
      r_rst_cnt       <= w_rst_cnt;
      r_stable_cnt    <= w_stable_cnt;
      r_timeout_cnt   <= w_timeout_cnt;
      r_stage_cnt     <= w_stage_cnt;
      r_pll_rst       <= w_pll_rst;
      r_domain_reset  <= w_domain_reset;
      r_all_ready     <= w_all_ready;
      r_relock_count  <= w_relock_count;
      r_timeout_count <= w_timeout_count;
    end
  end

  // Domain resets release by shifting zeros in from bit 0, so release order cannot be violated.
  always_comb begin
    w_state         = r_state;
    w_rst_cnt       = r_rst_cnt;
    w_stable_cnt    = r_stable_cnt;
    w_timeout_cnt   = r_timeout_cnt;
    w_stage_cnt     = r_stage_cnt;
    w_pll_rst       = r_pll_rst;
    w_domain_reset  = r_domain_reset;
    w_all_ready     = r_all_ready;
    w_relock_count  = r_relock_count;
    w_timeout_count = r_timeout_count;

    case (r_state)
      S_PLL_RST: begin
        w_pll_rst      = 1'b1;
        w_domain_reset = '1;
        w_all_ready    = 1'b0;
        if (r_rst_cnt == RST_LAST) begin
          w_state       = S_WAIT_LOCK;
          w_pll_rst     = 1'b0;
          w_rst_cnt     = '0;
          w_stable_cnt  = '0;
          w_timeout_cnt = '0;
        end else begin
          w_rst_cnt = r_rst_cnt + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        if (w_lock_ok && (r_stable_cnt == STB_LAST)) begin
          w_domain_reset = FIRST_REL;
          w_stable_cnt   = '0;
          w_timeout_cnt  = '0;
          w_stage_cnt    = '0;
          if (NUM_DOMAINS == 1) begin
            w_state     = S_RUN;
            w_all_ready = 1'b1;
          end else begin
            w_state = S_RELEASE;
          end
        end else if (TO_EN && (r_timeout_cnt == TO_LAST)) begin
          w_state         = S_PLL_RST;
          w_pll_rst       = 1'b1;
          w_rst_cnt       = '0;
          w_stable_cnt    = '0;
          w_timeout_cnt   = '0;
          w_timeout_count = (r_timeout_count == 8'hFF) ? r_timeout_count : r_timeout_count + 8'd1;
        end else begin
          w_stable_cnt = w_lock_ok ? r_stable_cnt + 1'b1 : '0;
          if (TO_EN) begin
            w_timeout_cnt = r_timeout_cnt + 1'b1;
          end
        end
      end

      S_RELEASE, S_RUN: begin
        if (!w_lock_ok) begin
          w_state        = S_PLL_RST;
          w_pll_rst      = 1'b1;
          w_domain_reset = '1;
          w_all_ready    = 1'b0;
          w_rst_cnt      = '0;
          w_relock_count = (r_relock_count == 8'hFF) ? r_relock_count : r_relock_count + 8'd1;
        end else if (bus.sw_reset_req) begin
          w_state        = S_WAIT_LOCK;
          w_domain_reset = '1;
          w_all_ready    = 1'b0;
          w_stable_cnt   = '0;
          w_timeout_cnt  = '0;
        end else if (r_state == S_RELEASE) begin
          if (r_stage_cnt == STG_LAST) begin
            w_domain_reset = r_domain_reset << 1;
            w_stage_cnt    = '0;
            if (w_domain_reset == '0) begin
              w_state     = S_RUN;
              w_all_ready = 1'b1;
            end
          end else begin
            w_stage_cnt = r_stage_cnt + 1'b1;
          end
        end
      end

      default: w_state = S_PLL_RST;
    endcase
  end

  assign bus.pll_rst       = r_pll_rst;
  assign bus.domain_reset  = r_domain_reset;
  assign bus.all_ready     = r_all_ready;
  assign bus.relock_count  = r_relock_count;
  assign bus.timeout_count = r_timeout_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: bring-up, glitches, timeouts, lock loss, sw re-sequence.
module tb_pll_reset_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  pll_reset_sequencer_if #(.NUM_LOCKS(2), .NUM_DOMAINS(3)) bus ();

  pll_reset_sequencer #(
    .NUM_LOCKS          (2),
    .NUM_DOMAINS        (3),
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .STAGE_DELAY_CYCLES (5),
    .LOCK_TIMEOUT_CYCLES(64)
  ) dut (
    .sys_clock(clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected domain_reset n edges after reset release on a clean bring-up.
  function automatic logic [2:0] exp_dom(input int e);
    if (e < 12) return 3'b111;
    if (e < 17) return 3'b110;
    if (e < 22) return 3'b100;
    return 3'b000;
  endfunction

  task automatic apply_reset(input logic [1:0] locks);
    reset_n          = 1'b0;
    bus.pll_locked   = locks;
    bus.sw_reset_req = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n          = 1'b0;
    bus.pll_locked   = 2'b11;
    bus.sw_reset_req = 1'b0;
    tick(2);
    checks++; if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.domain_reset !== 3'b111) begin failures++; $display("FAIL reset_dom got=%b exp=111", bus.domain_reset); end
    checks++; if (bus.all_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.all_ready); end
    checks++; if (bus.relock_count !== 8'd0) begin failures++; $display("FAIL reset_relock got=%0d exp=0", bus.relock_count); end
    checks++; if (bus.timeout_count !== 8'd0) begin failures++; $display("FAIL reset_timeout got=%0d exp=0", bus.timeout_count); end
  endtask

  task automatic test_clean_bringup;
    apply_reset(2'b11);
    for (int e = 1; e <= 22; e++) begin
      tick(1);
      checks++; if (bus.domain_reset !== exp_dom(e)) begin failures++; $display("FAIL clean_dom e=%0d got=%b exp=%b", e, bus.domain_reset, exp_dom(e)); end
      checks++; if (bus.pll_rst !== (e <= 3)) begin failures++; $display("FAIL clean_pll_rst e=%0d got=%b exp=%b", e, bus.pll_rst, (e <= 3)); end
      checks++; if (bus.all_ready !== (e >= 22)) begin failures++; $display("FAIL clean_ready e=%0d got=%b exp=%b", e, bus.all_ready, (e >= 22)); end
    end
    checks++; if (bus.relock_count !== 8'd0) begin failures++; $display("FAIL clean_relock got=%0d exp=0", bus.relock_count); end
    checks++; if (bus.timeout_count !== 8'd0) begin failures++; $display("FAIL clean_timeout got=%0d exp=0", bus.timeout_count); end
  endtask

  task automatic test_lock_glitch;
    apply_reset(2'b11);
    tick(8);
    bus.pll_locked = 2'b01;
    tick(1);
    bus.pll_locked = 2'b11;
    for (int e = 10; e <= 29; e++) begin
      tick(1);
      checks++; if (bus.domain_reset !== exp_dom(e - 7)) begin failures++; $display("FAIL glitch_dom e=%0d got=%b exp=%b", e, bus.domain_reset, exp_dom(e - 7)); end
      checks++; if (bus.all_ready !== (e >= 29)) begin failures++; $display("FAIL glitch_ready e=%0d got=%b exp=%b", e, bus.all_ready, (e >= 29)); end
    end
    checks++; if (bus.relock_count !== 8'd0) begin failures++; $display("FAIL glitch_relock got=%0d exp=0", bus.relock_count); end
    checks++; if (bus.timeout_count !== 8'd0) begin failures++; $display("FAIL glitch_timeout got=%0d exp=0", bus.timeout_count); end
  endtask

  // sw_reset_req pulses in WAIT_LOCK (e=30) and PLL_RST (e=69) must not disturb the retry rhythm.
  task automatic test_timeout;
    apply_reset(2'b10);
    for (int e = 1; e <= 204; e++) begin
      bus.sw_reset_req = (e == 30 || e == 69);
      tick(1);
      checks++; if (bus.pll_rst !== ((e % 68) <= 3)) begin failures++; $display("FAIL timeout_pll_rst e=%0d got=%b exp=%b", e, bus.pll_rst, ((e % 68) <= 3)); end
      checks++; if (bus.timeout_count !== 8'(e / 68)) begin failures++; $display("FAIL timeout_count e=%0d got=%0d exp=%0d", e, bus.timeout_count, e / 68); end
      checks++; if (bus.domain_reset !== 3'b111 || bus.all_ready !== 1'b0) begin failures++; $display("FAIL timeout_dom e=%0d got=%b/%b exp=111/0", e, bus.domain_reset, bus.all_ready); end
    end
    bus.sw_reset_req = 1'b0;
  endtask

  task automatic test_lock_loss_run;
    apply_reset(2'b11);
    tick(22);
    checks++; if (bus.all_ready !== 1'b1) begin failures++; $display("FAIL loss_pre_ready got=%b exp=1", bus.all_ready); end
    bus.pll_locked = 2'b10;
    tick(1);
    bus.pll_locked = 2'b11;
    tick(1);
    checks++; if (bus.domain_reset !== 3'b000) begin failures++; $display("FAIL loss_edge2_dom got=%b exp=000", bus.domain_reset); end
    tick(1);
    checks++; if (bus.domain_reset !== 3'b111) begin failures++; $display("FAIL loss_dom got=%b exp=111", bus.domain_reset); end
    checks++; if (bus.all_ready !== 1'b0) begin failures++; $display("FAIL loss_ready got=%b exp=0", bus.all_ready); end
    checks++; if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.relock_count !== 8'd1) begin failures++; $display("FAIL loss_relock got=%0d exp=1", bus.relock_count); end
    for (int e = 1; e <= 22; e++) begin
      tick(1);
      checks++; if (bus.domain_reset !== exp_dom(e)) begin failures++; $display("FAIL reseq_dom e=%0d got=%b exp=%b", e, bus.domain_reset, exp_dom(e)); end
      checks++; if (bus.pll_rst !== (e <= 3)) begin failures++; $display("FAIL reseq_pll_rst e=%0d got=%b exp=%b", e, bus.pll_rst, (e <= 3)); end
    end
    checks++; if (bus.all_ready !== 1'b1) begin failures++; $display("FAIL reseq_ready got=%b exp=1", bus.all_ready); end
    checks++; if (bus.relock_count !== 8'd1) begin failures++; $display("FAIL reseq_relock got=%0d exp=1", bus.relock_count); end
  endtask

  task automatic test_sw_reset;
    bus.sw_reset_req = 1'b1;
    tick(1);
    bus.sw_reset_req = 1'b0;
    checks++; if (bus.domain_reset !== 3'b111 || bus.all_ready !== 1'b0) begin failures++; $display("FAIL sw_dom got=%b/%b exp=111/0", bus.domain_reset, bus.all_ready); end
    for (int e = 2; e <= 19; e++) begin
      tick(1);
      checks++; if (bus.domain_reset !== exp_dom(e + 3)) begin failures++; $display("FAIL sw_reseq_dom e=%0d got=%b exp=%b", e, bus.domain_reset, exp_dom(e + 3)); end
      checks++; if (bus.pll_rst !== 1'b0) begin failures++; $display("FAIL sw_pll_rst e=%0d got=%b exp=0", e, bus.pll_rst); end
    end
    checks++; if (bus.all_ready !== 1'b1) begin failures++; $display("FAIL sw_ready got=%b exp=1", bus.all_ready); end
    checks++; if (bus.relock_count !== 8'd1) begin failures++; $display("FAIL sw_relock got=%0d exp=1", bus.relock_count); end
    checks++; if (bus.timeout_count !== 8'd0) begin failures++; $display("FAIL sw_timeout got=%0d exp=0", bus.timeout_count); end
  endtask

  task automatic test_sw_with_lock_loss;
    bus.pll_locked = 2'b10;
    tick(1);
    bus.pll_locked = 2'b11;
    tick(1);
    checks++; if (bus.domain_reset !== 3'b000) begin failures++; $display("FAIL simul_pre_dom got=%b exp=000", bus.domain_reset); end
    bus.sw_reset_req = 1'b1;
    tick(1);
    bus.sw_reset_req = 1'b0;
    checks++; if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL simul_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.domain_reset !== 3'b111 || bus.all_ready !== 1'b0) begin failures++; $display("FAIL simul_dom got=%b/%b exp=111/0", bus.domain_reset, bus.all_ready); end
    checks++; if (bus.relock_count !== 8'd2) begin failures++; $display("FAIL simul_relock got=%0d exp=2", bus.relock_count); end
    tick(3);
    checks++; if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL simul_hold got=%b exp=1", bus.pll_rst); end
    tick(1);
    checks++; if (bus.pll_rst !== 1'b0) begin failures++; $display("FAIL simul_release got=%b exp=0", bus.pll_rst); end
  endtask

  task automatic test_saturation_and_async_reset;
    bit found;
    apply_reset(2'b10);
    tick(68 * 255 - 1);
    checks++; if (bus.timeout_count !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", bus.timeout_count); end
    tick(1);
    checks++; if (bus.timeout_count !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", bus.timeout_count); end
    tick(68 * 45);
    checks++; if (bus.timeout_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", bus.timeout_count); end
    checks++; if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL sat_pll_rst got=%b exp=1", bus.pll_rst); end
    bus.pll_locked = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick(1);
      if (bus.domain_reset === 3'b110) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL sat_reach_release got=%b exp=110", bus.domain_reset); end
    tick(2);
    checks++; if (bus.domain_reset !== 3'b110) begin failures++; $display("FAIL mid_release_dom got=%b exp=110", bus.domain_reset); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.domain_reset !== 3'b111) begin failures++; $display("FAIL async_dom got=%b exp=111", bus.domain_reset); end
    checks++; if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL async_pll_rst got=%b exp=1", bus.pll_rst); end
    checks++; if (bus.all_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%b exp=0", bus.all_ready); end
    checks++; if (bus.timeout_count !== 8'd0) begin failures++; $display("FAIL async_timeout got=%0d exp=0", bus.timeout_count); end
    tick(1);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_lock_glitch();
    test_timeout();
    test_lock_loss_run();
    test_sw_reset();
    test_sw_with_lock_loss();
    test_saturation_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
